// File: rtl/ahb_master.sv
// AHB-Lite initiator: turns a valid/ready command stream into pipelined transfers, one response per command.
// Build option AHB_MASTER_SEQ_EN: merge address-contiguous commands into SEQ beats of an INCR burst.
module ahb_master #(
  parameter int A_WIDTH = 32,
  parameter int D_WIDTH = 32
) (
  input  logic               hclk_i,
  input  logic               hreset_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_write_i,
  input  logic [A_WIDTH-1:0] cmd_addr_i,
  input  logic [2:0]         cmd_size_i,
  input  logic [D_WIDTH-1:0] cmd_wdata_i,
  output logic               rsp_valid_o,
  output logic [D_WIDTH-1:0] rsp_rdata_o,
  output logic               rsp_err_o,
  output logic [A_WIDTH-1:0] haddr_o,
  output logic [1:0]         htrans_o,
  output logic [2:0]         hsize_o,
  output logic [2:0]         hburst_o,
  output logic [3:0]         hprot_o,
  output logic               hwrite_o,
  output logic [D_WIDTH-1:0] hwdata_o,
  input  logic               hready_i,
  input  logic [1:0]         hresp_i,
  input  logic [D_WIDTH-1:0] hrdata_i
);

  localparam int LANE_W = (D_WIDTH == 64) ? 3 : 2;
  localparam int NBYTES = D_WIDTH / 8;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;

  function automatic logic [A_WIDTH-1:0] align_addr(input logic [A_WIDTH-1:0] addr,
                                                    input logic [2:0]         size);
    logic [A_WIDTH-1:0] low_mask;
    low_mask = (A_WIDTH'(1) << size) - A_WIDTH'(1);
    return addr & ~low_mask;
  endfunction

  function automatic logic [D_WIDTH-1:0] to_lanes(input logic [D_WIDTH-1:0] data,
                                                  input logic [LANE_W-1:0]  lane);
    return data << {lane, 3'b000};
  endfunction

  // Bring the addressed bytes down to bit 0 and clear everything above the transfer size.
  function automatic logic [D_WIDTH-1:0] from_lanes(input logic [D_WIDTH-1:0] data,
                                                    input logic [LANE_W-1:0]  lane,
                                                    input logic [2:0]         size);
    logic [D_WIDTH-1:0] shifted;
    logic [D_WIDTH-1:0] res;
    shifted = data >> {lane, 3'b000};
    res     = '0;
    for (int b = 0; b < NBYTES; b++) begin
      if (b < (1 << size)) res[b*8 +: 8] = shifted[b*8 +: 8];
    end
    return res;
  endfunction

  logic               accept;
  logic               addr_active;
  logic               data_done;
  logic [A_WIDTH-1:0] addr_al;
  logic [1:0]         trans_sel;
  logic [2:0]         burst_sel;
  logic [D_WIDTH-1:0] wdata_p1;
  logic               vld_p2;
  logic               write_p2;
  logic [2:0]         size_p2;
  logic [LANE_W-1:0]  lane_p2;

  assign cmd_ready_o = hready_i & ~hreset_i;
  assign accept      = cmd_valid_i & cmd_ready_o;
  assign addr_al     = align_addr(cmd_addr_i, cmd_size_i);
  assign addr_active = (htrans_o != HTRANS_IDLE);
  assign data_done   = vld_p2 & hready_i;
  assign hprot_o     = 4'b0011;

`ifdef AHB_MASTER_SEQ_EN
  logic [A_WIDTH-1:0] next_addr;
  logic               seq_hit;

  // The bus address is advancing this cycle (accept implies hready), so it is the predecessor.
  assign next_addr = haddr_o + (A_WIDTH'(1) << hsize_o);
  assign seq_hit   = addr_active
                   && (cmd_write_i == hwrite_o)
                   && (cmd_size_i == hsize_o)
                   && (addr_al == next_addr)
                   && (addr_al[9:0] != 10'd0);
  assign trans_sel = seq_hit ? HTRANS_SEQ : HTRANS_NONSEQ;
  assign burst_sel = HBURST_INCR;
`else
  assign trans_sel = HTRANS_NONSEQ;
  assign burst_sel = HBURST_SINGLE;
`endif

  // Stage p1: address phase, registered straight onto the bus
  always_ff @(posedge hclk_i) begin
    if (hreset_i) begin
      htrans_o <= HTRANS_IDLE;
      haddr_o  <= '0;
      hsize_o  <= '0;
      hwrite_o <= 1'b0;
      hburst_o <= HBURST_SINGLE;
    end else if (accept) begin
      htrans_o <= trans_sel;
      haddr_o  <= addr_al;
      hsize_o  <= cmd_size_i;
      hwrite_o <= cmd_write_i;
      hburst_o <= burst_sel;
    end else if (hready_i) begin
      htrans_o <= HTRANS_IDLE;
      hburst_o <= HBURST_SINGLE;
    end
  end

  always_ff @(posedge hclk_i) begin
    if (accept) wdata_p1 <= to_lanes(cmd_wdata_i, addr_al[LANE_W-1:0]);
  end

  // Stage p2: data phase, held until the slave signals ready
  always_ff @(posedge hclk_i) begin
    if (hreset_i) begin
      vld_p2   <= 1'b0;
      hwdata_o <= '0;
    end else if (hready_i) begin
      vld_p2 <= addr_active;
      if (addr_active && hwrite_o) hwdata_o <= wdata_p1;
    end
  end

  always_ff @(posedge hclk_i) begin
    if (hready_i && addr_active) begin
      write_p2 <= hwrite_o;
      size_p2  <= hsize_o;
      lane_p2  <= haddr_o[LANE_W-1:0];
    end
  end

  // Response: one pulse the cycle after the data phase completes; RETRY/SPLIT count as errors
  always_ff @(posedge hclk_i) begin
    if (hreset_i) begin
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
    end else begin
      rsp_valid_o <= data_done;
      rsp_err_o   <= data_done && (hresp_i != HRESP_OKAY);
      rsp_rdata_o <= (data_done && !write_p2) ? from_lanes(hrdata_i, lane_p2, size_p2) : '0;
    end
  end

endmodule

// File: tb/tb_ahb_master.sv
// Bench for ahb_master: directed scenarios with literal expectations plus a randomized run,
// all checked every cycle against a transaction-level model of the bus and response stream.
module tb_ahb_master;

  logic        hclk_i = 1'b0;
  logic        hreset_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_write_i;
  logic [31:0] cmd_addr_i;
  logic [2:0]  cmd_size_i;
  logic [31:0] cmd_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [31:0] haddr_o;
  logic [1:0]  htrans_o;
  logic [2:0]  hsize_o;
  logic [2:0]  hburst_o;
  logic [3:0]  hprot_o;
  logic        hwrite_o;
  logic [31:0] hwdata_o;
  logic        hready_i;
  logic [1:0]  hresp_i;
  logic [31:0] hrdata_i;

  ahb_master #(.A_WIDTH(32), .D_WIDTH(32)) dut (
    .hclk_i(hclk_i), .hreset_i(hreset_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_size_i(cmd_size_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .haddr_o(haddr_o), .htrans_o(htrans_o), .hsize_o(hsize_o), .hburst_o(hburst_o),
    .hprot_o(hprot_o), .hwrite_o(hwrite_o), .hwdata_o(hwdata_o),
    .hready_i(hready_i), .hresp_i(hresp_i), .hrdata_i(hrdata_i)
  );

  always #5 hclk_i = ~hclk_i;

`ifdef AHB_MASTER_SEQ_EN
  localparam logic [1:0] T_CONT = 2'd3;
  localparam logic [2:0] B_EXP  = 3'd1;
`else
  localparam logic [1:0] T_CONT = 2'd2;
  localparam logic [2:0] B_EXP  = 3'd0;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int n_exp_rsp = 0;
  int n_dut_rsp = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfer as seen on the bus: what the address phase shows and what the data phase needs.
  typedef struct packed {
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_t;

  xfer_t       m_ap, m_dp;
  logic        m_dp_vld;
  logic [31:0] m_hwdata;
  logic        m_rsp_vld, m_rsp_err;
  logic [31:0] m_rsp_rdata;
  logic [31:0] m_al;
  logic        m_seq;
  logic        live = 1'b0;

  function automatic logic [31:0] exp_read(input logic [31:0] d, input logic [31:0] a,
                                           input logic [2:0] s);
    logic [63:0] w;
    w = {32'b0, d} >> (8 * a[1:0]);
    w = w & ((64'd1 << (8 << s)) - 64'd1);
    return w[31:0];
  endfunction

  function automatic logic [31:0] exp_lanes(input logic [31:0] d, input logic [31:0] a);
    return d << (8 * a[1:0]);
  endfunction

  always @(posedge hclk_i) begin
    if (hreset_i === 1'b1) begin
      m_ap = '0; m_dp = '0; m_dp_vld = 1'b0; m_hwdata = '0;
      m_rsp_vld = 1'b0; m_rsp_err = 1'b0; m_rsp_rdata = '0;
      live = 1'b1;
    end else if (live) begin
      m_rsp_vld   = m_dp_vld && hready_i;
      m_rsp_err   = m_rsp_vld && (hresp_i != 2'b00);
      m_rsp_rdata = (m_rsp_vld && !m_dp.wr) ? exp_read(hrdata_i, m_dp.addr, m_dp.size) : '0;
      if (m_rsp_vld) n_exp_rsp++;
      if (hready_i) begin
        m_dp_vld = (m_ap.trans != 2'b00);
        if (m_dp_vld) begin
          m_dp = m_ap;
          if (m_ap.wr) m_hwdata = exp_lanes(m_ap.wdata, m_ap.addr);
        end
        if (cmd_valid_i) begin
          m_al = cmd_addr_i & ~((32'd1 << cmd_size_i) - 32'd1);
`ifdef AHB_MASTER_SEQ_EN
          m_seq = (m_ap.trans != 2'b00) && (m_ap.wr == cmd_write_i) && (m_ap.size == cmd_size_i)
                  && (m_al == m_ap.addr + (32'd1 << cmd_size_i)) && (m_al[9:0] != 10'd0);
`else
          m_seq = 1'b0;
`endif
          m_ap.trans = m_seq ? 2'b11 : 2'b10;
          m_ap.wr    = cmd_write_i;
          m_ap.size  = cmd_size_i;
          m_ap.addr  = m_al;
          m_ap.wdata = cmd_wdata_i;
        end else begin
          m_ap.trans = 2'b00;
        end
      end
    end
  end

  always @(negedge hclk_i) begin
    if (live) begin
      chk("cmd_ready", cmd_ready_o, hready_i && !hreset_i);
      chk("htrans", htrans_o, m_ap.trans);
      chk("hprot", hprot_o, 4'b0011);
      if (m_ap.trans != 2'b00) begin
        chk("haddr", haddr_o, m_ap.addr);
        chk("hsize", hsize_o, m_ap.size);
        chk("hwrite", hwrite_o, m_ap.wr);
        chk("hburst", hburst_o, B_EXP);
      end
      if (m_dp_vld && m_dp.wr) chk("hwdata", hwdata_o, m_hwdata);
      chk("rsp_valid", rsp_valid_o, m_rsp_vld);
      if (m_rsp_vld) begin
        chk("rsp_err", rsp_err_o, m_rsp_err);
        chk("rsp_rdata", rsp_rdata_o, m_rsp_rdata);
      end
      if (rsp_valid_o === 1'b1) n_dut_rsp++;
    end
  end

  task automatic step(input logic v, input logic wr, input logic [31:0] a, input logic [2:0] s,
                      input logic [31:0] wd, input logic hr, input logic [1:0] rp,
                      input logic [31:0] rd, input logic rst);
    @(posedge hclk_i);
    #1;
    hreset_i = rst; cmd_valid_i = v; cmd_write_i = wr; cmd_addr_i = a; cmd_size_i = s;
    cmd_wdata_i = wd; hready_i = hr; hresp_i = rp; hrdata_i = rd;
    @(negedge hclk_i);
  endtask

  task automatic idle(input logic hr, input logic [1:0] rp, input logic [31:0] rd,
                      input logic rst);
    step(1'b0, 1'b0, 32'h0, 3'd0, 32'h0, hr, rp, rd, rst);
  endtask

  task automatic run_random(input int cycles);
    logic        cv, cw, lw, have, rst, hr;
    logic [31:0] ca, cwd, la;
    logic [2:0]  cs, ls;
    logic [1:0]  rp;
    cv = 0; cw = 0; lw = 0; have = 0; ca = 0; cwd = 0; la = 0; cs = 0; ls = 0;
    for (int n = 0; n < cycles; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      hr  = ($urandom_range(0, 3) != 0);
      rp  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (!cv && $urandom_range(0, 9) < 7) begin
        cv  = 1'b1;
        cwd = $urandom;
        if (have && $urandom_range(0, 1) == 1) begin
          cw = lw; cs = ls; ca = la + (32'd1 << ls);
        end else begin
          cw = 1'($urandom_range(0, 1));
          cs = 3'($urandom_range(0, 2));
          ca = 32'h83C0 + $urandom_range(0, 127);
        end
      end
      step(cv, cw, ca, cs, cwd, hr, rp, $urandom, rst);
      if (cv && hr && !rst) begin
        cv = 1'b0; have = 1'b1; lw = cw; ls = cs;
        la = ca & ~((32'd1 << cs) - 32'd1);
      end
      if (rst) have = 1'b0;
    end
  endtask

  logic [31:0] a_hw [4] = '{32'h000000EF, 32'h0000EF00, 32'h00EF0000, 32'hEF000000};

  initial begin
    hreset_i = 1; cmd_valid_i = 0; cmd_write_i = 0; cmd_addr_i = 0; cmd_size_i = 0;
    cmd_wdata_i = 0; hready_i = 1; hresp_i = 0; hrdata_i = 0;
    repeat (3) idle(1, 0, 0, 1);
    idle(1, 0, 0, 0);
    chk("rst_htrans", htrans_o, 2'd0);
    chk("rst_haddr", haddr_o, 32'h0);
    chk("rst_hsize", hsize_o, 3'd0);
    chk("rst_hwrite", hwrite_o, 1'b0);
    chk("rst_hwdata", hwdata_o, 32'h0);
    chk("rst_hburst", hburst_o, 3'd0);
    chk("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata_o, 32'h0);
    chk("rst_rsp_err", rsp_err_o, 1'b0);

    // Back-to-back byte writes, one per lane
    for (int i = 0; i < 8; i++) begin
      if (i < 4) step(1, 1, 32'h8000 + i, 3'd0, 32'hEF, 1, 0, 0, 0);
      else       idle(1, 0, 0, 0);
      if (i == 1) begin
        chk("A_htrans0", htrans_o, 2'd2);
        chk("A_haddr0", haddr_o, 32'h8000);
      end
      if (i == 2) chk("A_htrans1", htrans_o, T_CONT);
      if (i >= 2 && i <= 5) chk("A_hwdata", hwdata_o, a_hw[i-2]);
      if (i >= 3 && i <= 6) begin
        chk("A_rsp_valid", rsp_valid_o, 1'b1);
        chk("A_rsp_err", rsp_err_o, 1'b0);
      end
      if (i == 7) chk("A_rsp_idle", rsp_valid_o, 1'b0);
    end

    // Halfword then word write: size change forces NONSEQ
    step(1, 1, 32'h8004, 3'd1, 32'h3210, 1, 0, 0, 0);
    step(1, 1, 32'h8008, 3'd2, 32'h76543210, 1, 0, 0, 0);
    chk("B_htrans0", htrans_o, 2'd2);
    chk("B_hsize0", hsize_o, 3'd1);
    idle(1, 0, 0, 0);
    chk("B_htrans1", htrans_o, 2'd2);
    chk("B_haddr1", haddr_o, 32'h8008);
    chk("B_hwdata0", hwdata_o, 32'h00003210);
    idle(1, 0, 0, 0);
    chk("B_hwdata1", hwdata_o, 32'h76543210);
    repeat (2) idle(1, 0, 0, 0);

    // Sub-word reads: lane extraction and zero extension
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 32'h8001, 3'd0, 0, 1, 0, 0, 0);
    step(1, 0, 32'h8006, 3'd1, 0, 1, 0, 0, 0);
    idle(1, 0, 32'hDEADBEEF, 0);
    idle(1, 0, 32'h76543210, 0);
    chk("C_rsp_valid0", rsp_valid_o, 1'b1);
    chk("C_rdata_byte", rsp_rdata_o, 32'h000000BE);
    idle(1, 0, 0, 0);
    chk("C_rdata_half", rsp_rdata_o, 32'h00007654);
    idle(1, 0, 0, 0);

    // Two wait states on the second of three reads
    step(1, 0, 32'h9000, 3'd2, 0, 1, 0, 0, 0);
    step(1, 0, 32'h9004, 3'd2, 0, 1, 0, 0, 0);
    step(1, 0, 32'h9008, 3'd2, 0, 1, 0, 32'h11111111, 0);
    idle(0, 0, 0, 0);
    chk("D_ready_w0", cmd_ready_o, 1'b0);
    chk("D_rsp0", rsp_valid_o, 1'b1);
    chk("D_rdata0", rsp_rdata_o, 32'h11111111);
    chk("D_haddr_w0", haddr_o, 32'h9008);
    chk("D_htrans_w0", htrans_o, T_CONT);
    idle(0, 0, 0, 0);
    chk("D_ready_w1", cmd_ready_o, 1'b0);
    chk("D_rsp_w1", rsp_valid_o, 1'b0);
    chk("D_haddr_w1", haddr_o, 32'h9008);
    idle(1, 0, 32'h22222222, 0);
    chk("D_rsp_w2", rsp_valid_o, 1'b0);
    chk("D_haddr_w2", haddr_o, 32'h9008);
    chk("D_htrans_w2", htrans_o, T_CONT);
    idle(1, 0, 32'h33333333, 0);
    chk("D_rsp1", rsp_valid_o, 1'b1);
    chk("D_rdata1", rsp_rdata_o, 32'h22222222);
    idle(1, 0, 0, 0);
    chk("D_rsp2", rsp_valid_o, 1'b1);
    chk("D_rdata2", rsp_rdata_o, 32'h33333333);
    idle(1, 0, 0, 0);
    chk("D_rsp_end", rsp_valid_o, 1'b0);

    // Two-cycle ERROR on the first write; the following beat is not cancelled
    step(1, 1, 32'h8004, 3'd1, 32'h1111, 1, 0, 0, 0);
    step(1, 1, 32'h8006, 3'd1, 32'h2222, 1, 0, 0, 0);
    idle(0, 1, 0, 0);
    chk("E_htrans1", htrans_o, T_CONT);
    chk("E_haddr1", haddr_o, 32'h8006);
    chk("E_hwdata0", hwdata_o, 32'h00001111);
    idle(1, 1, 0, 0);
    chk("E_haddr_hold", haddr_o, 32'h8006);
    chk("E_rsp_wait", rsp_valid_o, 1'b0);
    idle(1, 0, 0, 0);
    chk("E_rsp0", rsp_valid_o, 1'b1);
    chk("E_err0", rsp_err_o, 1'b1);
    chk("E_hwdata1", hwdata_o, 32'h22220000);
    idle(1, 0, 0, 0);
    chk("E_rsp1", rsp_valid_o, 1'b1);
    chk("E_err1", rsp_err_o, 1'b0);
    idle(1, 0, 0, 0);

    // Reset during a data phase drops the transfer
    step(1, 1, 32'hA000, 3'd2, 32'hCAFEF00D, 1, 0, 0, 0);
    idle(1, 0, 0, 0);
    chk("F_htrans", htrans_o, 2'd2);
    idle(1, 0, 0, 1);
    chk("F_ready_rst", cmd_ready_o, 1'b0);
    chk("F_hwdata", hwdata_o, 32'hCAFEF00D);
    idle(1, 0, 0, 0);
    chk("F_htrans_rst", htrans_o, 2'd0);
    chk("F_rsp_rst", rsp_valid_o, 1'b0);
    chk("F_hwdata_rst", hwdata_o, 32'h0);
    for (int i = 0; i < 3; i++) begin
      idle(1, 0, 0, 0);
      chk("F_no_stale", rsp_valid_o, 1'b0);
    end

    run_random(3000);
    repeat (6) idle(1, 0, 0, 0);
    chk("rsp_count", n_dut_rsp, n_exp_rsp);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
